// File: rtl/data_bus_2to2_arbiter.sv
// Round-robin arbiter and crossbar mux for a shared 2-to-2 data bus.
// A granted configuration is held for HOLD_CYCLES cycles, then the bus returns to IDLE for at least one cycle.
module data_bus_2to2_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             dst1,
    input  logic [WIDTH-1:0] data1,
    input  logic             req2,
    input  logic             dst2,
    input  logic [WIDTH-1:0] data2,
    output logic             select,
    output logic             grant1,
    output logic             grant2,
    output logic [WIDTH-1:0] dataOut1,
    output logic [WIDTH-1:0] dataOut2,
    output logic             valid1,
    output logic             valid2,
    output logic             busy
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           ptr, ptr_nx;
    logic           sel_nx, g1_nx, g2_nx, v1_nx, v2_nx;
    logic           win1, win2;

    // Next-state and registered-output decode
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        sel_nx   = select;
        g1_nx    = grant1;
        g2_nx    = grant2;
        v1_nx    = valid1;
        v2_nx    = valid2;
        win1     = 1'b0;
        win2     = 1'b0;
        case (state)
            IDLE: begin
                if (req1 || req2) begin
                    win1 = req1;
                    win2 = req2;
                    // Same destination: pointer picks the winner and then moves to the loser
                    if (req1 && req2 && (dst1 == dst2)) begin
                        win1   = ~ptr;
                        win2   = ptr;
                        ptr_nx = ~ptr;
                    end
                    sel_nx   = win1 ? dst1 : ~dst2;
                    g1_nx    = win1;
                    g2_nx    = win2;
                    v1_nx    = (win1 && !dst1) || (win2 && !dst2);
                    v2_nx    = (win1 && dst1) || (win2 && dst2);
                    cnt_nx   = CW'(HOLD_CYCLES - 1);
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    sel_nx   = 1'b0;
                    g1_nx    = 1'b0;
                    g2_nx    = 1'b0;
                    v1_nx    = 1'b0;
                    v2_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= 1'b0;
            select <= 1'b0;
            grant1 <= 1'b0;
            grant2 <= 1'b0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ptr    <= ptr_nx;
            select <= sel_nx;
            grant1 <= g1_nx;
            grant2 <= g2_nx;
            valid1 <= v1_nx;
            valid2 <= v2_nx;
        end
    end

    assign busy = (state == XFER);

    // Bus mux: live data steered by registered select, blanked when not valid
    assign dataOut1 = valid1 ? (select ? data2 : data1) : '0;
    assign dataOut2 = valid2 ? (select ? data1 : data2) : '0;

endmodule
